axis_dispatcher: RTL and testbench

Splits one AXI-Stream packet flow (64-bit data, 80-bit user sideband) into two output channels, selecting the channel per packet from a type field in the first beat's user word. It is the receive-side counterpart of the two-into-one channel arbiter: it sits between the MAC or IP receive path and the two upper-layer consumers (MAC: IP vs ARP; IP: UDP vs ICMP). Routing decisions are locked for the whole packet. Both outputs are registered, and each output has independent backpressure.

---
 rtl/axis_dispatcher_pkg.sv | 48 ++++
 rtl/axis_reg_slice.sv | 30 +++
 rtl/axis_dispatcher.sv | 135 +++++++++++++
 tb/tb_axis_dispatcher.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_dispatcher_pkg.sv
// Shared definitions for the receive-side dispatcher and its transmit-side arbiter:
// FSM encoding, user sideband field positions, protocol constants, beat struct.
package axis_dispatcher_pkg;

  localparam int DATA_W = 64;
  localparam int USER_W = 80;
  localparam int KEEP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FWD_C0 = 2'd1,
    ST_FWD_C1 = 2'd2
  } state_e;

  localparam int ETYPE_MSB   = 63;
  localparam int ETYPE_LSB   = 48;
  localparam int IPPROTO_MSB = 39;
  localparam int IPPROTO_LSB = 32;
  localparam int MAC_LEN_MSB = 79;
  localparam int MAC_LEN_LSB = 64;
  localparam int IP_LEN_MSB  = 55;
  localparam int IP_LEN_LSB  = 40;

  localparam logic [15:0] ETH_IPV4   = 16'h0800;
  localparam logic [15:0] ETH_ARP    = 16'h0806;
  localparam logic [7:0]  PROTO_UDP  = 8'h11;
  localparam logic [7:0]  PROTO_ICMP = 8'h01;

  localparam logic [23:0] LAYER_MAC = "MAC";
  localparam logic [23:0] LAYER_IP  = {8'h00, "IP"};

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [USER_W-1:0] user;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  // IP mode compares only the low byte of the match key against the protocol field
  function automatic logic key_match(input logic [23:0]       layer,
                                     input logic [USER_W-1:0] user,
                                     input logic [15:0]       match);
    if (layer == LAYER_IP)
      return user[IPPROTO_MSB:IPPROTO_LSB] == match[7:0];
    return user[ETYPE_MSB:ETYPE_LSB] == match;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry register slice carrying one full beat (data/user/keep/last) with valid/ready.
module axis_reg_slice
  import axis_dispatcher_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  beat_t in_beat,
  output logic  free,
  output logic  out_valid,
  output beat_t out_beat,
  input  logic  out_ready
);

  assign free = !out_valid || out_ready;

  // load is only raised while free, so a pending beat is never overwritten
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_beat  <= in_beat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_dispatcher.sv
// Routes whole AXI-Stream packets to c0 or c1 by a key in the first beat's user word.
module axis_dispatcher
  import axis_dispatcher_pkg::*;
#(
  parameter logic [23:0] P_DISPATCH_LAYER = "MAC",
  parameter logic [15:0] P_C0_MATCH       = 16'h0800
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] s_axis_in_data,
  input  logic [USER_W-1:0] s_axis_in_user,
  input  logic [KEEP_W-1:0] s_axis_in_keep,
  input  logic              s_axis_in_last,
  input  logic              s_axis_in_valid,
  output logic              s_axis_in_ready,
  output logic [DATA_W-1:0] m_axis_c0_data,
  output logic [USER_W-1:0] m_axis_c0_user,
  output logic [KEEP_W-1:0] m_axis_c0_keep,
  output logic              m_axis_c0_last,
  output logic              m_axis_c0_valid,
  input  logic              m_axis_c0_ready,
  output logic [DATA_W-1:0] m_axis_c1_data,
  output logic [USER_W-1:0] m_axis_c1_user,
  output logic [KEEP_W-1:0] m_axis_c1_keep,
  output logic              m_axis_c1_last,
  output logic              m_axis_c1_valid,
  input  logic              m_axis_c1_ready,
  output logic [15:0]       o_c0_pkt_cnt,
  output logic [15:0]       o_c1_pkt_cnt
);

  state_e            state, state_nxt;
  logic [USER_W-1:0] user_q;
  logic              c0_free, c1_free;
  logic              load_c0, load_c1;
  logic              in_ready, accept, match;
  beat_t             in_beat, c0_beat, c1_beat;

  assign match  = key_match(P_DISPATCH_LAYER, s_axis_in_user, P_C0_MATCH);
  assign accept = s_axis_in_valid && in_ready;

  // later beats reuse the user word latched from the first beat
  assign in_beat.data = s_axis_in_data;
  assign in_beat.user = (state == ST_IDLE) ? s_axis_in_user : user_q;
  assign in_beat.keep = s_axis_in_keep;
  assign in_beat.last = s_axis_in_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ready never looks at s_axis_in_valid; IDLE needs both slices since the target is unknown
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_c0   = 1'b0;
    load_c1   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = c0_free && c1_free;
        if (s_axis_in_valid && in_ready) begin
          load_c0 = match;
          load_c1 = !match;
          if (!s_axis_in_last) state_nxt = match ? ST_FWD_C0 : ST_FWD_C1;
        end
      end
      ST_FWD_C0: begin
        in_ready = c0_free;
        if (s_axis_in_valid && in_ready) begin
          load_c0 = 1'b1;
          if (s_axis_in_last) state_nxt = ST_IDLE;
        end
      end
      ST_FWD_C1: begin
        in_ready = c1_free;
        if (s_axis_in_valid && in_ready) begin
          load_c1 = 1'b1;
          if (s_axis_in_last) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign s_axis_in_ready = in_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst)                            user_q <= '0;
    else if (state == ST_IDLE && accept)  user_q <= s_axis_in_user;
  end

  axis_reg_slice u_slice_c0 (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (load_c0),
    .in_beat   (in_beat),
    .free      (c0_free),
    .out_valid (m_axis_c0_valid),
    .out_beat  (c0_beat),
    .out_ready (m_axis_c0_ready)
  );

  axis_reg_slice u_slice_c1 (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (load_c1),
    .in_beat   (in_beat),
    .free      (c1_free),
    .out_valid (m_axis_c1_valid),
    .out_beat  (c1_beat),
    .out_ready (m_axis_c1_ready)
  );

  assign m_axis_c0_data = c0_beat.data;
  assign m_axis_c0_user = c0_beat.user;
  assign m_axis_c0_keep = c0_beat.keep;
  assign m_axis_c0_last = c0_beat.last;
  assign m_axis_c1_data = c1_beat.data;
  assign m_axis_c1_user = c1_beat.user;
  assign m_axis_c1_keep = c1_beat.keep;
  assign m_axis_c1_last = c1_beat.last;

  // packets are counted when their last beat leaves the slice
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_c0_pkt_cnt <= '0;
      o_c1_pkt_cnt <= '0;
    end else begin
      if (m_axis_c0_valid && m_axis_c0_ready && m_axis_c0_last) o_c0_pkt_cnt <= o_c0_pkt_cnt + 16'd1;
      if (m_axis_c1_valid && m_axis_c1_ready && m_axis_c1_last) o_c1_pkt_cnt <= o_c1_pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_dispatcher.sv
// Scoreboard bench: a MAC-mode and an IP-mode dispatcher, packet-level routing model, negedge monitor.
module tb_axis_dispatcher;

  typedef struct packed {
    logic [63:0] data;
    logic [79:0] user;
    logic [7:0]  keep;
    logic        last;
  } tbeat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic [63:0] in_data  [2];
  logic [79:0] in_user  [2];
  logic [7:0]  in_keep  [2];
  logic        in_last  [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic [63:0] o_data   [2][2];
  logic [79:0] o_user   [2][2];
  logic [7:0]  o_keep   [2][2];
  logic        o_last   [2][2];
  logic        o_valid  [2][2];
  logic        rdy      [2][2];
  logic [15:0] cnt      [2][2];

  tbeat_t      exp_q    [2][2][$];
  logic [15:0] mcnt     [2][2];
  logic        stall    [2][2];
  tbeat_t      prev     [2][2];
  bit          rand_rdy = 0;
  int          tests = 0, fails = 0;

  axis_dispatcher #(.P_DISPATCH_LAYER("MAC"), .P_C0_MATCH(16'h0800)) u_mac (
    .i_clk(clk), .i_rst(rst[0]),
    .s_axis_in_data(in_data[0]), .s_axis_in_user(in_user[0]), .s_axis_in_keep(in_keep[0]),
    .s_axis_in_last(in_last[0]), .s_axis_in_valid(in_valid[0]), .s_axis_in_ready(in_ready[0]),
    .m_axis_c0_data(o_data[0][0]), .m_axis_c0_user(o_user[0][0]), .m_axis_c0_keep(o_keep[0][0]),
    .m_axis_c0_last(o_last[0][0]), .m_axis_c0_valid(o_valid[0][0]), .m_axis_c0_ready(rdy[0][0]),
    .m_axis_c1_data(o_data[0][1]), .m_axis_c1_user(o_user[0][1]), .m_axis_c1_keep(o_keep[0][1]),
    .m_axis_c1_last(o_last[0][1]), .m_axis_c1_valid(o_valid[0][1]), .m_axis_c1_ready(rdy[0][1]),
    .o_c0_pkt_cnt(cnt[0][0]), .o_c1_pkt_cnt(cnt[0][1])
  );

  axis_dispatcher #(.P_DISPATCH_LAYER({8'h00, "IP"}), .P_C0_MATCH(16'h0011)) u_ip (
    .i_clk(clk), .i_rst(rst[1]),
    .s_axis_in_data(in_data[1]), .s_axis_in_user(in_user[1]), .s_axis_in_keep(in_keep[1]),
    .s_axis_in_last(in_last[1]), .s_axis_in_valid(in_valid[1]), .s_axis_in_ready(in_ready[1]),
    .m_axis_c0_data(o_data[1][0]), .m_axis_c0_user(o_user[1][0]), .m_axis_c0_keep(o_keep[1][0]),
    .m_axis_c0_last(o_last[1][0]), .m_axis_c0_valid(o_valid[1][0]), .m_axis_c0_ready(rdy[1][0]),
    .m_axis_c1_data(o_data[1][1]), .m_axis_c1_user(o_user[1][1]), .m_axis_c1_keep(o_keep[1][1]),
    .m_axis_c1_last(o_last[1][1]), .m_axis_c1_valid(o_valid[1][1]), .m_axis_c1_ready(rdy[1][1]),
    .o_c0_pkt_cnt(cnt[1][0]), .o_c1_pkt_cnt(cnt[1][1])
  );

  task automatic chk(input string nm, input logic [152:0] act, input logic [152:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // routing rule from the key alone: MAC 0x0800 -> c0, IP proto 0x11 -> c0, else c1
  function automatic int route(input int d, input logic [79:0] u);
    if (d == 0) return (u[63:48] == 16'h0800) ? 0 : 1;
    return (u[39:32] == 8'h11) ? 0 : 1;
  endfunction

  // called at posedge+1; returns at posedge+1 just after reset released
  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    in_valid[d] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      exp_q[d][c].delete();
      mcnt[d][c] = 16'd0;
    end
    @(posedge clk); #1;
    rst[d] = 1'b0;
  endtask

  task automatic chk_reset(input int d);
    @(negedge clk);
    chk("rst_c0_valid", 153'(o_valid[d][0]), 153'd0);
    chk("rst_c1_valid", 153'(o_valid[d][1]), 153'd0);
    chk("rst_c0_cnt",   153'(cnt[d][0]),     153'd0);
    chk("rst_c1_cnt",   153'(cnt[d][1]),     153'd0);
    chk("rst_in_ready", 153'(in_ready[d]),   153'd1);
    @(posedge clk); #1;
  endtask

  // starts and ends at posedge+1 so consecutive packets go back to back
  task automatic send_pkt(input int d, input int n, input logic [15:0] key,
                          input int klast, input int rst_at);
    tbeat_t b;
    logic [95:0] r;
    logic [31:0] k;
    int ch, wt;
    r = {$urandom, $urandom, $urandom};
    b.user = r[79:0];
    if (d == 0) b.user[63:48] = key;
    else        b.user[39:32] = key[7:0];
    ch = route(d, b.user);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        do_reset(d);
        return;
      end
      b.data = {$urandom, $urandom};
      k = $urandom;
      b.keep = k[7:0];
      b.last = (i == n - 1);
      if (b.last && klast >= 0) b.keep = klast[7:0];
      r = {$urandom, $urandom, $urandom};
      in_data[d]  = b.data;
      in_user[d]  = (i == 0) ? b.user : r[79:0];
      in_keep[d]  = b.keep;
      in_last[d]  = b.last;
      in_valid[d] = 1'b1;
      wt = 0;
      @(negedge clk);
      while (!in_ready[d] && wt < 1000) begin
        @(negedge clk);
        wt++;
      end
      if (!in_ready[d]) begin
        chk("in_ready_timeout", 153'(in_ready[d]), 153'd1);
        in_valid[d] = 1'b0;
        @(posedge clk); #1;
        return;
      end
      exp_q[d][ch].push_back(b);
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int wt = 0;
    while ((exp_q[0][0].size() + exp_q[0][1].size() + exp_q[1][0].size() + exp_q[1][1].size()) != 0
           && wt < 2000) begin
      @(posedge clk);
      wt++;
    end
    #1;
    chk("drain_left", 153'(exp_q[0][0].size() + exp_q[0][1].size() + exp_q[1][0].size()
                          + exp_q[1][1].size()), 153'd0);
  endtask

  // transfer happens at the next posedge when valid && ready at this negedge
  always @(negedge clk) begin
    tbeat_t got, e;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (rst[d]) begin
          stall[d][c] = 1'b0;
        end else begin
          got = {o_data[d][c], o_user[d][c], o_keep[d][c], o_last[d][c]};
          chk($sformatf("pkt_cnt_d%0d_c%0d", d, c), 153'(cnt[d][c]), 153'(mcnt[d][c]));
          if (stall[d][c]) begin
            chk($sformatf("stall_valid_d%0d_c%0d", d, c), 153'(o_valid[d][c]), 153'd1);
            chk($sformatf("stall_stable_d%0d_c%0d", d, c), got, prev[d][c]);
          end
          if (o_valid[d][c] && rdy[d][c]) begin
            if (exp_q[d][c].size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_beat_d%0d_c%0d: got %h expected none", d, c, got);
            end else begin
              e = exp_q[d][c].pop_front();
              chk($sformatf("beat_d%0d_c%0d", d, c), got, e);
              if (e.last) mcnt[d][c] = mcnt[d][c] + 16'd1;
            end
          end
          stall[d][c] = o_valid[d][c] && !rdy[d][c];
          prev[d][c]  = got;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy)
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < 2; c++)
            rdy[d][c] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [15:0] key;
    int sel;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = '0; in_user[d] = '0;
      in_keep[d] = '0; in_last[d] = 1'b0;
      for (int c = 0; c < 2; c++) begin
        rdy[d][c] = 1'b1; mcnt[d][c] = 16'd0; stall[d][c] = 1'b0; prev[d][c] = '0;
      end
    end
    idle(2);
    do_reset(0);
    chk_reset(0);
    do_reset(1);
    chk_reset(1);

    send_pkt(0, 4, 16'h0800, 8'h0F, -1);
    idle(3);
    chk("t1_c0_cnt", 153'(cnt[0][0]), 153'd1);
    chk("t1_c1_cnt", 153'(cnt[0][1]), 153'd0);

    send_pkt(0, 3, 16'h0800, -1, -1);
    send_pkt(0, 3, 16'h0806, -1, -1);
    send_pkt(0, 3, 16'h0800, -1, -1);
    drain();
    chk("alt_c0_cnt", 153'(cnt[0][0]), 153'd3);
    chk("alt_c1_cnt", 153'(cnt[0][1]), 153'd1);

    rdy[0][1] = 1'b0;
    fork
      send_pkt(0, 6, 16'h0806, -1, -1);
      begin
        repeat (4) @(negedge clk);
        chk("stall_in_ready", 153'(in_ready[0]), 153'd0);
        chk("stall_c1_full",  153'(o_valid[0][1]), 153'd1);
        repeat (7) @(posedge clk);
        #1 rdy[0][1] = 1'b1;
      end
    join
    drain();
    chk("stall_c1_cnt", 153'(cnt[0][1]), 153'd2);

    send_pkt(1, 1, 16'h0011, -1, -1);
    send_pkt(1, 1, 16'h0001, -1, -1);
    drain();
    chk("ip_c0_cnt", 153'(cnt[1][0]), 153'd1);
    chk("ip_c1_cnt", 153'(cnt[1][1]), 153'd1);

    send_pkt(0, 5, 16'h0800, -1, 1);
    chk_reset(0);
    send_pkt(0, 3, 16'h0806, -1, -1);
    drain();
    chk("post_rst_c0_cnt", 153'(cnt[0][0]), 153'd0);
    chk("post_rst_c1_cnt", 153'(cnt[0][1]), 153'd1);

    rand_rdy = 1;
    for (int p = 0; p < 200; p++) begin
      sel = $urandom_range(0, 3);
      key = $urandom;
      if (p % 2 == 0) begin
        if (sel == 0 || sel == 2) key = 16'h0800;
        else if (sel == 1) key = 16'h0806;
        send_pkt(0, $urandom_range(1, 6), key, -1, -1);
      end else begin
        if (sel == 0 || sel == 2) key = 16'h0011;
        else if (sel == 1) key = 16'h0001;
        send_pkt(1, $urandom_range(1, 6), key, -1, -1);
      end
    end
    rand_rdy = 0;
    idle(1);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++)
        rdy[d][c] = 1'b1;
    drain();

    do_reset(0);
    chk_reset(0);
    for (int p = 0; p < 65536; p++) send_pkt(0, 1, 16'h0800, -1, -1);
    drain();
    idle(2);
    chk("wrap_c0_cnt", 153'(cnt[0][0]), 153'd0);
    chk("wrap_c1_cnt", 153'(cnt[0][1]), 153'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
